// File: rtl/ctrl_pkg.sv
// Shared definitions for the instruction control sequencer: FSM state
// encoding, fixed fetch T-step indices and the strobe bundle with its decoder.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_EXEC,
        ST_HALTED
    } seq_state_e;

    // Fixed fetch step indices; execute steps start at STEP_EXEC_FIRST.
    localparam int STEP_T0         = 0;
    localparam int STEP_T1         = 1;
    localparam int STEP_T2         = 2;
    localparam int STEP_EXEC_FIRST = 3;

    typedef struct packed {
        logic pc_out;
        logic mar_in;
        logic inc_pc;
        logic z_in;
        logic zlow_out;
        logic pc_in;
        logic mdr_in;
        logic read;
        logic mdr_out;
        logic ir_in;
        logic exec_en;
    } strobe_t;

    // Strobes belonging to a state; pc_in is only wanted on the first T1 cycle.
    function automatic strobe_t strobes_for(input seq_state_e st, input logic first_t1);
        strobe_t s;
        s = '0;
        case (st)
            ST_T0: begin
                s.pc_out = 1'b1;
                s.mar_in = 1'b1;
                s.inc_pc = 1'b1;
                s.z_in   = 1'b1;
            end
            ST_T1: begin
                s.zlow_out = 1'b1;
                s.pc_in    = first_t1;
                s.mdr_in   = 1'b1;
                s.read     = 1'b1;
            end
            ST_T2: begin
                s.mdr_out = 1'b1;
                s.ir_in   = 1'b1;
            end
            ST_EXEC: s.exec_en = 1'b1;
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/step_counter.sv
// T-step index register: load has priority over increment, otherwise hold.
module step_counter #(
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [STEP_W-1:0] load_val,
    input  logic              inc,
    output logic [STEP_W-1:0] count
);

    logic [STEP_W-1:0] count_reg;

    // Load / increment / hold of the current step index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (inc) begin
            count_reg <= count_reg + STEP_W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute control sequencer.
// Fetch runs T0 (PC to MAR, increment), T1 (memory read, waits on mem_ready),
// T2 (MDR to IR); execute steps follow until end_instr or the last step.
// Optional feature: define SEQ_TIMEOUT_EN to bound the T1 memory wait; on
// expiry err latches and the sequencer halts. Without it err is tied low.
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int NUM_STEPS   = 8,
    parameter int STEP_W      = 4,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              run,
    input  logic              stall,
    input  logic              mem_ready,
    input  logic              end_instr,
    input  logic              halt_req,
    output logic [STEP_W-1:0] step,
    output logic              pc_out,
    output logic              mar_in,
    output logic              inc_pc,
    output logic              z_in,
    output logic              zlow_out,
    output logic              pc_in,
    output logic              mdr_in,
    output logic              read,
    output logic              mdr_out,
    output logic              ir_in,
    output logic              exec_en,
    output logic              busy,
    output logic              halted,
    output logic              err
);

    if (NUM_STEPS < 4 || NUM_STEPS > 16 || STEP_W < $clog2(NUM_STEPS) || TIMEOUT_CYC < 1) begin : g_param_check
        $error("control_sequencer: illegal parameter combination");
    end

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

    // Reset asserts asynchronously and releases through two flops so the
    // first state change happens well clear of the clr rising edge.
    logic [1:0] rst_sync_reg;
    logic       rst_core_n;

    // Reset release synchroniser.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rst_sync_reg <= 2'b00;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
        end
    end

    assign rst_core_n = rst_sync_reg[1];

    seq_state_e        state_reg;
    seq_state_e        state_next;
    strobe_t           strb_reg;
    logic [STEP_W-1:0] step_cnt;
    logic [STEP_W-1:0] step_load_val;
    logic              step_load;
    logic              step_inc;

`ifdef SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] to_cnt_reg;
    logic            err_reg;
    logic            timeout_hit;

    // Fires on the unready T1 cycle that exhausts the wait budget.
    assign timeout_hit = (state_reg == ST_T1) && !mem_ready &&
                         (to_cnt_reg == TO_W'(TIMEOUT_CYC - 1));

    // Count unready, unstalled T1 cycles; latch err on expiry.
    always_ff @(posedge clk or negedge rst_core_n) begin
        if (!rst_core_n) begin
            to_cnt_reg <= '0;
            err_reg    <= 1'b0;
        end else if (!stall) begin
            if (state_reg == ST_T1 && state_next == ST_T1) begin
                to_cnt_reg <= to_cnt_reg + TO_W'(1);
            end else begin
                to_cnt_reg <= '0;
            end
            if (timeout_hit) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    // Next-state and step-counter control; a stall freezes everything.
    always_comb begin
        state_next    = state_reg;
        step_load     = 1'b0;
        step_load_val = '0;
        step_inc      = 1'b0;
        if (!stall) begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (run) begin
                        state_next    = ST_T0;
                        step_load     = 1'b1;
                        step_load_val = STEP_W'(STEP_T0);
                    end
                end
                ST_T0: begin
                    state_next    = ST_T1;
                    step_load     = 1'b1;
                    step_load_val = STEP_W'(STEP_T1);
                end
                ST_T1: begin
                    if (mem_ready) begin
                        state_next    = ST_T2;
                        step_load     = 1'b1;
                        step_load_val = STEP_W'(STEP_T2);
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (timeout_hit) begin
                        state_next    = ST_HALTED;
                        step_load     = 1'b1;
                        step_load_val = STEP_W'(STEP_T0);
                    end
`endif
                end
                ST_T2: begin
                    state_next    = ST_EXEC;
                    step_load     = 1'b1;
                    step_load_val = STEP_W'(STEP_EXEC_FIRST);
                end
                ST_EXEC: begin
                    if (end_instr || step_cnt == LAST_STEP) begin
                        step_load     = 1'b1;
                        step_load_val = STEP_W'(STEP_T0);
                        if (halt_req) begin
                            state_next = ST_HALTED;
                        end else if (run) begin
                            state_next = ST_T0;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        step_inc = 1'b1;
                    end
                end
                default: state_next = state_reg;
            endcase
        end
    end

    // State register plus strobes decoded from the next state, so strobes
    // line up with the step index. A stall holds everything but drops read.
    always_ff @(posedge clk or negedge rst_core_n) begin
        if (!rst_core_n) begin
            state_reg <= ST_IDLE;
            strb_reg  <= '0;
        end else if (stall) begin
            strb_reg.read <= 1'b0;
        end else begin
            state_reg <= state_next;
            strb_reg  <= strobes_for(state_next, state_reg == ST_T0);
        end
    end

    step_counter #(
        .STEP_W (STEP_W)
    ) u_step_counter (
        .clk      (clk),
        .rst_n    (rst_core_n),
        .load     (step_load),
        .load_val (step_load_val),
        .inc      (step_inc),
        .count    (step_cnt)
    );

    assign step     = step_cnt;
    assign pc_out   = strb_reg.pc_out;
    assign mar_in   = strb_reg.mar_in;
    assign inc_pc   = strb_reg.inc_pc;
    assign z_in     = strb_reg.z_in;
    assign zlow_out = strb_reg.zlow_out;
    assign pc_in    = strb_reg.pc_in;
    assign mdr_in   = strb_reg.mdr_in;
    assign read     = strb_reg.read;
    assign mdr_out  = strb_reg.mdr_out;
    assign ir_in    = strb_reg.ir_in;
    assign exec_en  = strb_reg.exec_en;
    assign busy     = (state_reg != ST_IDLE) && (state_reg != ST_HALTED);
    assign halted   = (state_reg == ST_HALTED);

endmodule
